sevensegment_scan: RTL and testbench
====================================

# sevensegment_scan

Time-multiplexed scan controller for a bank of common-anode/common-cathode seven-segment digits sharing one segment bus. Holds a per-digit hex value, decimal-point and blank mask behind a valid/ready load port, commits new contents only at frame boundaries (no tearing), and sequences digits with a programmable slot length and anti-ghosting dead time. A single instance of the team's hex-to-seven-segment decoder (`sevensegment`) is shared across all digits. The block sits between a memory-mapped debug/status register and the board-level display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..16)
- CLK_DIV, 50000, clock cycles per digit slot (≥ 4)
- DEAD_CYCLES, 16, anode-off cycles at the start of each slot (1..CLK_DIV-2)
- SEG_ACTIVE_LOW, 1, 1: seg_o/dp_o driven low = lit
- AN_ACTIVE_LOW, 1, 1: an_o driven low = digit selected
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous and active-low
- enable_i  in  1  scan enable; low forces display dark
- valid_i  in  1  load request
- ready_o  out  1  load accepted when valid_i && ready_o
- value_i  in  4*NUM_DIGITS  hex nibble per digit, digit k = value_i[4k+3:4k]
- dp_i  in  NUM_DIGITS  decimal point per digit
- blank_i  in  NUM_DIGITS  1 = digit k dark
- seg_o  out  7  segments, bit0=a … bit6=g
- dp_o  out  1  decimal point
- an_o  out  NUM_DIGITS  digit selects

## Operation
- Registers: pending {value, dp, blank} + pending_flag; display {value, dp, blank}; slot counter cnt (0..CLK_DIV-1); digit index idx (0..NUM_DIGITS-1); state.
- States: OFF, DEAD, ON.
  - OFF: enable_i low. cnt=0, idx=0. enable_i high → DEAD.
  - DEAD: cnt 0..DEAD_CYCLES-1, anodes inactive, seg_o/dp_o already show digit idx. At cnt=DEAD_CYCLES-1 → ON.
  - ON: cnt DEAD_CYCLES..CLK_DIV-1, an_o[idx] active unless display blank[idx]. At cnt=CLK_DIV-1: cnt←0, idx←idx+1 (wraps NUM_DIGITS-1→0), → DEAD.
  - enable_i low in DEAD/ON → OFF next cycle, from any cnt/idx.
- Decode: decoder input = display value[idx]; seg_o = pattern (inverted if SEG_ACTIVE_LOW); dp_o = display dp[idx]. Blanked digit: seg_o, dp_o and an_o all inactive for its whole slot.
- Load: ready_o = !pending_flag. Handshake captures inputs into pending, sets pending_flag.
- Commit: pending → display, flag cleared, when pending_flag set and either (ON, idx=NUM_DIGITS-1, cnt=CLK_DIV-1) or state=OFF. Handshake on the commit cycle is captured, committed at the next commit point.
- Outputs idle (OFF, DEAD anodes, blanked) = inactive level per polarity parameters.

## Timing
- Reset values: an_o all inactive, seg_o all inactive, dp_o inactive, ready_o=1, pending_flag=0, display value 0, dp 0, blank all 1 (dark until first load), state OFF, cnt=0, idx=0.
- All outputs registered; reflect state one cycle after the transition that causes them.
- First enable_i sample high at edge E: state DEAD from E; an_o active for digit 0 from edge E+DEAD_CYCLES+1 for CLK_DIV-DEAD_CYCLES cycles.
- Frame = NUM_DIGITS*CLK_DIV cycles; each digit lit CLK_DIV-DEAD_CYCLES cycles per frame.
- Commit at frame end: new contents visible from digit 0 of the next frame; ready_o high the cycle after commit.
- Commit in OFF: one cycle after handshake.
- Reset mid-operation: all outputs inactive immediately (asynchronous), pending load discarded.

## Test plan
Parameters NUM_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, both polarities active-low.
- Reset, enable_i=0 → an_o=4'hF, seg_o=7'h7F, dp_o=1, ready_o=1; enable_i=1 with no load → an_o stays 4'hF (blank reset state).
- Load value 16'h3A50, dp 4'b0010, blank 0 while OFF, then enable → per slot, after 2 dead cycles (an_o=4'hF): digit0 an 4'hE seg 7'h40; digit1 an 4'hD seg 7'h12 dp_o=0; digit2 an 4'hB seg 7'h08; digit3 an 4'h7 seg 7'h30; 6 lit cycles each.
- Load while scanning digit 1 → ready_o=0 until one cycle after digit 3 slot ends; second valid_i during ready_o=0 ignored; new values appear from digit 0 of next frame only.
- Load blank 4'b1000 → digit 3 slot: an_o=4'hF, seg_o=7'h7F, dp_o=1 for all 8 cycles; digits 0–2 unaffected.
- enable_i low during digit 2 ON → an_o=4'hF next cycle; re-enable → restarts digit 0 with 2 dead cycles.
- rst_ni pulse mid-slot with a pending load → outputs inactive immediately, ready_o=1, pending contents never displayed.

Source files
------------

// File: rtl/sevensegment_scan.sv
// sevensegment_scan
//   Time-multiplexed scan controller for a bank of seven-segment digits that
//   share one segment bus. A valid/ready port loads a per-digit hex value,
//   decimal point and blank mask into a pending buffer. The pending buffer is
//   copied to the displayed buffer only at a frame boundary, or immediately
//   while the scan is off, so a frame never shows a mix of old and new digits.
//   Every digit slot starts with a dead time where all anodes are off, which
//   stops the previous digit from ghosting onto the next one.
//
// Ports
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   enable_i  scan enable; low forces the display dark
//   valid_i   load request
//   ready_o   load accepted when valid_i && ready_o
//   value_i   hex nibble per digit, digit k = value_i[4k+3:4k]
//   dp_i      decimal point per digit
//   blank_i   1 = digit dark
//   seg_o     segments a..g on bits 0..6
//   dp_o      decimal point
//   an_o      digit selects
//
// States
//   OFF  | scan disabled, cnt and idx held at 0, outputs dark
//   DEAD | start of slot, anodes off, segment bus already shows digit idx
//   ON   | anode of digit idx active unless that digit is blanked

module sevensegment (
    input  logic [3:0] value,
    output logic [6:0] segments
);
    // Active-high pattern, bit0 = a ... bit6 = g.
    always_comb begin
        case (value)
            4'h0:    segments = 7'h3F;
            4'h1:    segments = 7'h06;
            4'h2:    segments = 7'h5B;
            4'h3:    segments = 7'h4F;
            4'h4:    segments = 7'h66;
            4'h5:    segments = 7'h6D;
            4'h6:    segments = 7'h7D;
            4'h7:    segments = 7'h07;
            4'h8:    segments = 7'h7F;
            4'h9:    segments = 7'h6F;
            4'hA:    segments = 7'h77;
            4'hB:    segments = 7'h7C;
            4'hC:    segments = 7'h39;
            4'hD:    segments = 7'h5E;
            4'hE:    segments = 7'h79;
            default: segments = 7'h71;
        endcase
    end
endmodule

module sevensegment_scan #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    // Idle levels; XOR with the active-high internal value gives pin level.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    pending_flag;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;

    logic                    slot_end;
    logic                    frame_end;
    logic                    commit;
    logic [3:0]              cur_value;
    logic [6:0]              pattern;
    logic [6:0]              seg_hi;
    logic                    dp_hi;
    logic [NUM_DIGITS-1:0]   an_hi;

    assign ready_o   = !pending_flag;
    assign slot_end  = (cnt == CNT_W'(CLK_DIV - 1));
    assign frame_end = (state == ON) && slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign commit    = pending_flag && (frame_end || state == OFF);
    assign cur_value = disp_value[{idx, 2'b00} +: 4];

    sevensegment u_decoder (
        .value    (cur_value),
        .segments (pattern)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= OFF;
            cnt          <= '0;
            idx          <= '0;
            pending_flag <= 1'b0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_blank   <= '1;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blank   <= '1;
        end else begin
            // Capture needs !pending_flag and commit needs pending_flag, so
            // both can never fire on the same edge.
            if (valid_i && !pending_flag) begin
                pend_value   <= value_i;
                pend_dp      <= dp_i;
                pend_blank   <= blank_i;
                pending_flag <= 1'b1;
            end
            if (commit) begin
                disp_value   <= pend_value;
                disp_dp      <= pend_dp;
                disp_blank   <= pend_blank;
                pending_flag <= 1'b0;
            end

            case (state)
                OFF: begin
                    cnt <= '0;
                    idx <= '0;
                    if (enable_i) state <= DEAD;
                end
                DEAD: begin
                    if (!enable_i) begin
                        state <= OFF;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DEAD_CYCLES - 1)) state <= ON;
                    end
                end
                ON: begin
                    if (!enable_i) begin
                        state <= OFF;
                        cnt   <= '0;
                        idx   <= '0;
                    end else if (slot_end) begin
                        state <= DEAD;
                        cnt   <= '0;
                        idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= OFF;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Output image for the current state. Gating with enable_i darkens the
    // pins on the same edge that moves the FSM to OFF.
    always_comb begin
        seg_hi = '0;
        dp_hi  = 1'b0;
        an_hi  = '0;
        if (enable_i && state != OFF && !disp_blank[idx]) begin
            seg_hi = pattern;
            dp_hi  = disp_dp[idx];
            if (state == ON) an_hi[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_o <= SEG_OFF;
            dp_o  <= DP_OFF;
            an_o  <= AN_OFF;
        end else begin
            seg_o <= seg_hi ^ SEG_OFF;
            dp_o  <= dp_hi ^ DP_OFF;
            an_o  <= an_hi ^ AN_OFF;
        end
    end
endmodule

// File: tb/tb_sevensegment_scan.sv
module tb_sevensegment_scan;
    localparam int ND = 4;
    localparam int CD = 8;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [7:0] len;
    } slot_t;

    slot_t exp_q[$];

    sevensegment_scan #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (CD),
        .DEAD_CYCLES    (DC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .valid_i  (valid),
        .ready_o  (ready),
        .value_i  (value),
        .dp_i     (dp),
        .blank_i  (blank),
        .seg_o    (seg),
        .dp_o     (dp_out),
        .an_o     (an)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_slot(input logic [3:0] a, input logic [6:0] s, input logic d);
        slot_t x;
        x.an  = a;
        x.seg = s;
        x.dp  = d;
        x.len = 8'(CD - DC);
        exp_q.push_back(x);
    endtask

    // Monitor: one observation per lit slot (anode run), compared with the
    // oldest expected slot.
    initial begin
        bit         tracking = 1'b0;
        bit         stable = 1'b0;
        logic [3:0] t_an = '0;
        logic [6:0] t_seg = '0;
        logic       t_dp = 1'b0;
        int         t_len = 0;
        int         slot_no = 0;
        slot_t      e;
        forever begin
            @(negedge clk);
            if (!mon_on || !rst_n) begin
                tracking = 1'b0;
            end else if (an != 4'hF) begin
                if (!tracking) begin
                    tracking = 1'b1;
                    stable   = 1'b1;
                    t_an     = an;
                    t_seg    = seg;
                    t_dp     = dp_out;
                    t_len    = 1;
                end else begin
                    t_len++;
                    if (an != t_an || seg != t_seg || dp_out != t_dp) stable = 1'b0;
                end
            end else if (tracking) begin
                tracking = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot%0d: unexpected lit slot an=%h seg=%h dp=%b len=%0d",
                             slot_no, t_an, t_seg, t_dp, t_len);
                end else begin
                    e = exp_q.pop_front();
                    if (t_an != e.an || t_seg != e.seg || t_dp != e.dp ||
                        t_len != int'(e.len) || !stable) begin
                        errors++;
                        $display("FAIL slot%0d: got an=%h seg=%h dp=%b len=%0d stable=%0d, expected an=%h seg=%h dp=%b len=%0d stable=1",
                                 slot_no, t_an, t_seg, t_dp, t_len, stable, e.an, e.seg, e.dp, e.len);
                    end
                end
                slot_no++;
            end
        end
    end

    initial begin
        int e0;
        int e2;
        int n;
        bit saw;

        // Reset state
        repeat (3) @(negedge clk);
        chk("in_reset_an", an, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp_out, 1'b1);
        chk("reset_ready", ready, 1'b1);

        // Enabled with the reset display (all blanked) stays dark
        enable = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (an != 4'hF || seg != 7'h7F || dp_out != 1'b1) saw = 1'b1;
        end
        chk("blank_after_reset", saw, 1'b0);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Load while OFF commits one cycle after the handshake
        value = 16'h3A50; dp = 4'b0010; blank = 4'b0000; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("off_load_ready_low", ready, 1'b0);
        @(negedge clk);
        chk("off_commit_ready_high", ready, 1'b1);

        for (int f = 0; f < 2; f++) begin
            push_slot(4'hE, 7'h40, 1'b1);
            push_slot(4'hD, 7'h12, 1'b0);
            push_slot(4'hB, 7'h08, 1'b1);
            push_slot(4'h7, 7'h30, 1'b1);
        end
        mon_on = 1'b1;
        enable = 1'b1;
        e0 = cyc + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an == 4'hF && n < 20);
        chk("first_lit_latency", n, DC + 2);

        // Load during digit 1 of frame 1; a second request while busy is dropped
        at_neg(e0 + 43);
        value = 16'h8E7B; dp = 4'b1001; blank = 4'b0000; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("mid_frame_ready_low", ready, 1'b0);
        push_slot(4'hE, 7'h03, 1'b0);
        push_slot(4'hD, 7'h78, 1'b1);
        push_slot(4'hB, 7'h06, 1'b1);
        push_slot(4'h7, 7'h00, 1'b0);
        at_neg(e0 + 50);
        value = 16'h0000; dp = 4'hF; blank = 4'b0000; valid = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        at_neg(e0 + 63);
        chk("ready_low_until_frame_end", ready, 1'b0);
        @(negedge clk);
        chk("ready_after_frame_commit", ready, 1'b1);

        // Blank digit 3
        at_neg(e0 + 70);
        value = 16'h8E7B; dp = 4'b0000; blank = 4'b1000; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        push_slot(4'hE, 7'h03, 1'b1);
        push_slot(4'hD, 7'h78, 1'b1);
        push_slot(4'hB, 7'h06, 1'b1);
        push_slot(4'hE, 7'h03, 1'b1);
        push_slot(4'hD, 7'h78, 1'b1);
        at_neg(e0 + 121);
        saw = 1'b0;
        repeat (8) begin
            if (an != 4'hF || seg != 7'h7F || dp_out != 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        chk("blank_digit3_slot_dark", saw, 1'b0);

        // Disable during digit 2 ON
        at_neg(e0 + 146);
        mon_on = 1'b0;
        at_neg(e0 + 148);
        chk("digit2_lit_before_disable", an, 4'hB);
        enable = 1'b0;
        at_neg(e0 + 150);
        chk("disable_an", an, 4'hF);
        chk("disable_seg", seg, 7'h7F);
        chk("disable_dp", dp_out, 1'b1);
        chk("scoreboard_drained_1", exp_q.size(), 0);

        // Re-enable restarts at digit 0 with dead time
        at_neg(e0 + 155);
        push_slot(4'hE, 7'h03, 1'b1);
        push_slot(4'hD, 7'h78, 1'b1);
        push_slot(4'hB, 7'h06, 1'b1);
        mon_on = 1'b1;
        enable = 1'b1;
        e2 = cyc + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an == 4'hF && n < 20);
        chk("reenable_latency", n, DC + 2);
        at_neg(e2 + 30);
        mon_on = 1'b0;
        chk("scoreboard_drained_2", exp_q.size(), 0);

        // Reset mid-slot with a pending load
        at_neg(e2 + 33);
        value = 16'h0000; dp = 4'b0000; blank = 4'b0000; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("pending_ready_low", ready, 1'b0);
        at_neg(e2 + 38);
        chk("digit0_lit_before_reset", an, 4'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_seg", seg, 7'h7F);
        chk("async_reset_dp", dp_out, 1'b1);
        chk("async_reset_ready", ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (an != 4'hF || seg != 7'h7F || dp_out != 1'b1) saw = 1'b1;
        end
        chk("pending_discarded", saw, 1'b0);
        chk("scoreboard_drained_3", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
